// File: rtl/hpdmc_rdcapture.sv
// DDR read-data capture for HPDMC: gates IDDR samples with a read-latency pipeline,
// assembles 2*DW burst words at a selectable half-cycle phase and calibrates that phase.
module hpdmc_rdcapture #(
  parameter int unsigned    DW     = 16,
  parameter int unsigned    BURST  = 4,
  parameter int unsigned    MAXLAT = 7,
  parameter logic [DW-1:0]  PAT_A  = 16'hA5A5,
  parameter logic [DW-1:0]  PAT_B  = 16'h5A5A
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DW-1:0]                 q0,
  input  logic [DW-1:0]                 q1,
  input  logic                          read,
  input  logic [$clog2(MAXLAT+1)-1:0]   lat,
  input  logic                          calib_start,
  output logic [2*DW-1:0]               rdata,
  output logic                          rvalid,
  output logic                          rlast,
  output logic                          phase,
  output logic                          calib_done,
  output logic                          calib_fail,
  output logic                          overrun
);

  localparam int unsigned LW    = $clog2(MAXLAT + 1);
  localparam int unsigned WORDS = BURST / 2;
  localparam int unsigned CW    = $clog2(WORDS + 1);
  localparam logic [2*DW-1:0] PAT = {PAT_A, PAT_B};

  typedef enum logic [2:0] {StIdle, StTry0, StTry1, StDone, StFail} cal_state_e;

  logic [LW-1:0]     lat_q, lat_eff;
  logic [MAXLAT-1:0] sr_q, sr_d;
  logic              launch, launch_dly_q, eff_launch;
  logic [CW-1:0]     cnt_q, cnt_cur, cnt_d;
  logic              win, is_last, idle;
  logic [DW-1:0]     q1_d_q;
  logic [2*DW-1:0]   word, rdata_q;
  logic              rvalid_q, rlast_q, overrun_q;

  cal_state_e        state_q;
  logic              phase_q, done_q, fail_q;
  logic              armed_q, armed_cur, mism_q, mism_cur, word_bad;
  logic              eval_q, eval_fail_q, try_st;

  always_comb begin
    lat_eff = lat;
    if (lat == '0) begin
      lat_eff = LW'(1);
    end else if (32'(lat) > MAXLAT) begin
      lat_eff = LW'(MAXLAT);
    end
  end

  always_comb begin
    launch = 1'b0;
    for (int i = 0; i < MAXLAT; i++) begin
      if (lat_q == LW'(i + 1)) launch = sr_q[i];
    end
  end

  assign sr_d = {sr_q[MAXLAT-2:0], read};

  // Each launch is consumed exactly once: immediately in phase 0, one cycle later in phase 1,
  // so a phase flip never drops or duplicates a burst.
  assign eff_launch = launch_dly_q | (launch & ~phase_q);

  assign cnt_cur = eff_launch ? CW'(WORDS) : cnt_q;
  assign win     = (cnt_cur != '0);
  assign is_last = (cnt_cur == CW'(1));
  assign cnt_d   = win ? (cnt_cur - CW'(1)) : '0;
  assign idle    = (sr_q == '0) && (cnt_q == '0) && !launch_dly_q;
  assign word    = phase_q ? {q1_d_q, q0} : {q0, q1};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_q        <= LW'(1);
      sr_q         <= '0;
      launch_dly_q <= 1'b0;
      cnt_q        <= '0;
      q1_d_q       <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (idle) lat_q <= lat_eff;
      sr_q         <= sr_d;
      launch_dly_q <= launch & phase_q;
      cnt_q        <= cnt_d;
      q1_d_q       <= q1;
      rvalid_q     <= win;
      rlast_q      <= win & is_last;
      if (win) rdata_q <= word;
      if (eff_launch && (cnt_q != '0)) overrun_q <= 1'b1;
    end
  end

  // Calibration: only bursts launched while in a TRY state are scored.
  assign try_st    = (state_q == StTry0) || (state_q == StTry1);
  assign armed_cur = eff_launch ? try_st : armed_q;
  assign mism_cur  = eff_launch ? 1'b0 : mism_q;
  assign word_bad  = (word != PAT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      armed_q     <= 1'b0;
      mism_q      <= 1'b0;
      eval_q      <= 1'b0;
      eval_fail_q <= 1'b0;
    end else begin
      eval_q <= 1'b0;
      if (calib_start) begin
        state_q <= StTry0;
        phase_q <= 1'b0;
        done_q  <= 1'b0;
        fail_q  <= 1'b0;
        armed_q <= 1'b0;
        mism_q  <= 1'b0;
      end else if (eval_q) begin
        // Anything launched up to now belongs to the old phase and is discarded.
        armed_q <= 1'b0;
        case (state_q)
          StTry0: begin
            if (!eval_fail_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StTry1;
              phase_q <= 1'b1;
            end
          end
          StTry1: begin
            if (!eval_fail_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFail;
              fail_q  <= 1'b1;
              phase_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (win && armed_cur) begin
        armed_q <= !is_last;
        mism_q  <= mism_cur | word_bad;
        if (is_last) begin
          eval_q      <= 1'b1;
          eval_fail_q <= mism_cur | word_bad;
        end
      end else begin
        armed_q <= armed_cur;
        mism_q  <= mism_cur;
      end
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign rlast      = rlast_q;
  assign phase      = phase_q;
  assign calib_done = done_q;
  assign calib_fail = fail_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Directed self-checking bench for hpdmc_rdcapture (DW=16, BURST=4, MAXLAT=7).
module tb_hpdmc_rdcapture;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] q0, q1;
  logic        read;
  logic [2:0]  lat;
  logic        calib_start;
  logic [31:0] rdata;
  logic        rvalid, rlast, phase, calib_done, calib_fail, overrun;

  int checks = 0;
  int errors = 0;

  hpdmc_rdcapture dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .q0          (q0),
    .q1          (q1),
    .read        (read),
    .lat         (lat),
    .calib_start (calib_start),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .rlast       (rlast),
    .phase       (phase),
    .calib_done  (calib_done),
    .calib_fail  (calib_fail),
    .overrun     (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b);
    q0 = a;
    q1 = b;
    tick();
  endtask

  task automatic pulse_read();
    read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic pulse_calib();
    calib_start = 1'b1;
    tick();
    calib_start = 1'b0;
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    q0          = '0;
    q1          = '0;
    read        = 1'b0;
    lat         = 3'd3;
    calib_start = 1'b0;
    ticks(2);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    check("rst_phase", phase, 0);
    check("rst_done", calib_done, 0);
    check("rst_fail", calib_fail, 0);
    check("rst_overrun", overrun, 0);
    sys_rst_n = 1'b1;
    ticks(3);

    // Basic read, lat=3, phase 0
    pulse_read();
    check("basic_pre", rvalid, 0);
    ticks(2);
    beat(16'h1111, 16'h2222);
    check("basic_v0", rvalid, 1);
    check("basic_d0", rdata, 32'h11112222);
    check("basic_l0", rlast, 0);
    beat(16'h3333, 16'h4444);
    check("basic_v1", rvalid, 1);
    check("basic_d1", rdata, 32'h33334444);
    check("basic_l1", rlast, 1);
    beat(16'h0000, 16'h0000);
    check("basic_end", rvalid, 0);
    check("basic_hold", rdata, 32'h33334444);
    ticks(8);

    // Back-to-back at minimum spacing: continuous rvalid, no overrun
    pulse_read();
    tick();
    pulse_read();
    for (int k = 0; k < 4; k++) begin
      beat(16'h0100 + 16'(k), 16'h0200 + 16'(k));
      check("b2b_v", rvalid, 1);
      check("b2b_d", rdata, {16'h0100 + 16'(k), 16'h0200 + 16'(k)});
      check("b2b_l", rlast, (k % 2 == 1) ? 1 : 0);
    end
    beat(16'h0, 16'h0);
    check("b2b_end", rvalid, 0);
    check("b2b_ovr", overrun, 0);
    ticks(8);

    // Overlapping reads: second burst supersedes after the first word
    pulse_read();
    pulse_read();
    tick();
    beat(16'hAAA0, 16'hBBB0);
    check("ovr_v0", rvalid, 1);
    check("ovr_d0", rdata, 32'hAAA0BBB0);
    check("ovr_flag0", overrun, 0);
    beat(16'hAAA1, 16'hBBB1);
    check("ovr_v1", rvalid, 1);
    check("ovr_l1", rlast, 0);
    check("ovr_flag1", overrun, 1);
    beat(16'hAAA2, 16'hBBB2);
    check("ovr_v2", rvalid, 1);
    check("ovr_d2", rdata, 32'hAAA2BBB2);
    check("ovr_l2", rlast, 1);
    beat(16'h0, 16'h0);
    check("ovr_end", rvalid, 0);
    check("ovr_sticky", overrun, 1);
    ticks(8);

    // Latency change while a read is in flight
    pulse_read();
    lat = 3'd5;
    ticks(2);
    beat(16'hC000, 16'hC001);
    check("lat3_v", rvalid, 1);
    check("lat3_d", rdata, 32'hC000C001);
    beat(16'hC002, 16'hC003);
    check("lat3_l", rlast, 1);
    ticks(8);
    pulse_read();
    ticks(3);
    check("lat5_early3", rvalid, 0);
    tick();
    check("lat5_early4", rvalid, 0);
    beat(16'hD000, 16'hD001);
    check("lat5_v", rvalid, 1);
    check("lat5_d", rdata, 32'hD000D001);
    beat(16'hD002, 16'hD003);
    check("lat5_l", rlast, 1);
    lat = 3'd0;
    ticks(10);
    pulse_read();
    check("lat0_pre", rvalid, 0);
    beat(16'hE000, 16'hE001);
    check("lat0_v", rvalid, 1);
    check("lat0_d", rdata, 32'hE000E001);
    beat(16'hE002, 16'hE003);
    check("lat0_l", rlast, 1);
    lat = 3'd3;
    ticks(10);

    // Asynchronous reset during the second word
    pulse_read();
    ticks(2);
    beat(16'hF000, 16'hF001);
    check("mid_v0", rvalid, 1);
    q0 = 16'hF002;
    q1 = 16'hF003;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rvalid", rvalid, 0);
    check("mid_rdata", rdata, 0);
    check("mid_rlast", rlast, 0);
    check("mid_overrun", overrun, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_nostale", rvalid, 0);
    end
    ticks(4);

    // Calibration succeeding at phase 1
    q0 = 16'h5A5A;
    q1 = 16'hA5A5;
    pulse_calib();
    check("cal1_phase0", phase, 0);
    check("cal1_done0", calib_done, 0);
    pulse_read();
    ticks(3);
    check("cal1_try0_v", rvalid, 1);
    check("cal1_try0_d", rdata, 32'h5A5AA5A5);
    tick();
    check("cal1_try0_l", rlast, 1);
    tick();
    check("cal1_phase1", phase, 1);
    check("cal1_nodone", calib_done, 0);
    check("cal1_nofail", calib_fail, 0);
    ticks(3);
    pulse_read();
    ticks(3);
    check("cal1_late", rvalid, 0);
    tick();
    check("cal1_try1_v", rvalid, 1);
    check("cal1_try1_d", rdata, 32'hA5A55A5A);
    tick();
    check("cal1_try1_l", rlast, 1);
    check("cal1_notyet", calib_done, 0);
    tick();
    check("cal1_done", calib_done, 1);
    check("cal1_phase", phase, 1);
    check("cal1_fail", calib_fail, 0);
    ticks(4);

    // Calibration failure on constant data
    q0 = 16'h0000;
    q1 = 16'h0000;
    pulse_calib();
    check("cal2_clr_done", calib_done, 0);
    check("cal2_phase0", phase, 0);
    pulse_read();
    ticks(8);
    pulse_read();
    ticks(8);
    check("cal2_fail", calib_fail, 1);
    check("cal2_phase", phase, 0);
    check("cal2_done", calib_done, 0);
    pulse_calib();
    check("cal2_clr_fail", calib_fail, 0);
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
